// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator for all base formats, with a
// two-entry valid/ready output buffer and a saturating illegal-opcode counter.
// Sits between instruction fetch and the execute operand mux.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter bit SHAMT_ZEXT = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [5:0]  shamt;
    logic [31:0] imm32;
    logic        dec_shift;
    entry_t      dec_entry;

    entry_t          e0_q, e0_d;
    entry_t          e1_q, e1_d;
    logic [1:0]      count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic push;
    logic pop;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    // RV64 shifts carry a 6-bit shamt; RV32 only 5 bits.
    assign shamt  = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

    // Combinational format decode and immediate assembly from the raw word.
    always_comb begin
        imm32         = 32'd0;
        dec_shift     = 1'b0;
        dec_entry.fmt = FMT_R;
        dec_entry.ill = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_entry.fmt = FMT_I;
                imm32         = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0010011: begin
                dec_entry.fmt = FMT_I;
                imm32         = {{20{instr[31]}}, instr[31:20]};
                dec_shift     = SHAMT_ZEXT && ((funct3 == 3'b001) || (funct3 == 3'b101));
            end
            7'b0100011: begin
                dec_entry.fmt = FMT_S;
                imm32         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                dec_entry.fmt = FMT_B;
                imm32         = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_entry.fmt = FMT_U;
                imm32         = {instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_entry.fmt = FMT_J;
                imm32         = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_entry.fmt = FMT_R;
            end
            default: begin
                dec_entry.fmt = FMT_ILL;
                dec_entry.ill = 1'b1;
            end
        endcase
        // Everything is built as 32 bits and widened from bit 31, which also
        // gives U-type its sign extension on RV64.
        dec_entry.imm = dec_shift ? XLEN'(shamt) : XLEN'($signed(imm32));
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Buffer next state: e0 is always the head, so an emptied buffer keeps
    // showing the last popped entry.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    e0_d    = dec_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    e0_d = dec_entry;
                end else if (push) begin
                    e1_d    = dec_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    e0_d    = e1_q;
                    count_d = 2'd1;
                end
            end
        endcase
        if (push && dec_entry.ill && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops all buffered entries at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imm         = e0_q.imm;
    assign fmt         = e0_q.fmt;
    assign illegal     = e0_q.ill;
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-format 12-bit sign extender.
- Decodes the RISC-V immediate format from the instruction opcode and assembles the immediate for every base format (I/S/B/U/J), sign-extended to XLEN.
- Carries results through a 2-entry valid/ready output buffer and keeps a saturating count of unrecognised opcodes.
- Sits between instruction fetch and the execute/ALU operand mux.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- SHAMT_ZEXT, 1:
  - 1: OP-IMM shifts (funct3 001/101) output the zero-extended shamt, which is instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64.
  - 0: shifts are treated as plain I-type.
- CNT_W, 16, width of the illegal-opcode counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instr is presented
- in_ready  out  1  block can accept; driven only from registered state
- instr  in  32  instruction word
- out_valid  out  1  head buffer entry valid
- out_ready  in  1  consumer accepts head entry
- imm  out  XLEN  extended immediate of head entry
- fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- illegal  out  1  head entry opcode unrecognised
- illegal_cnt  out  CNT_W  accepted illegal instructions, saturating

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-high. On rst:
  - buffer count=0, out_valid=0, imm=0, fmt=0, illegal=0, illegal_cnt=0, in_ready=1 after release.
  - Reset asserted mid-operation discards all buffered entries immediately; no partial output.
- Opcode decode (instr[6:0]):
  - I: 0000011, 0010011, 1100111, 1110011 → instr[31:20], sign-extended.
  - S: 0100011 → {instr[31:25], instr[11:7]}, sign-extended.
  - B: 1100011 → {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U: 0110111, 0010111 → {instr[31:12], 12'b0}, sign-extended from bit 31 (matters for XLEN=64).
  - J: 1101111 → {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - R: 0110011 → imm=0, fmt=0.
  - Anything else → imm=0, fmt=7, illegal=1.
- Decode is combinational on instr. The result is written into the buffer on accept (in_valid & in_ready).
- Buffer: 2-entry FIFO, strict in-order.
  - in_ready = (count < 2), with no combinational path from out_ready.
  - Outputs always reflect the head entry; out_valid = (count > 0).
  - When out_valid=0, imm/fmt/illegal hold their last values; consumers ignore them.
- Latency: an instruction accepted on edge N is visible on outputs after edge N (1 cycle) if the buffer was empty.
- Throughput: 1 per cycle while out_ready=1.
- Count update per edge:
  - push only: +1.
  - pop only (out_valid & out_ready): −1.
  - push and pop together at count=1: count stays 1; the new entry becomes head next cycle.
  - push and pop together at count=0 cannot occur, since pop requires out_valid.
  - At count=2, in_ready=0, so no push; a pop frees one slot for the next cycle.
- Output stability: while out_valid=1 and out_ready=0, the head entry is held unchanged.
- illegal_cnt increments on accept of an illegal instruction, not on pop. It saturates at 2^CNT_W−1 and never wraps.

Test Plan:
1. XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, fmt=1, imm=0xFFFFFFFF. With XLEN=64 → imm=0xFFFFFFFFFFFFFFFF.
2. Back-to-back, one per cycle:
   - 0xFE112E23 → S, imm=0xFFFFFFFC.
   - 0xFE000FE3 → B, imm=0xFFFFFFFE.
   - 0x800002B7 → U, imm=0x80000000 (XLEN=64: 0xFFFFFFFF80000000).
   - 0x001000EF → J, imm=0x00000800.
   - Required: outputs in order on consecutive cycles, in_ready held 1.
3. 0x4030D093 (srai x1,x1,3) → SHAMT_ZEXT=1 gives imm=0x00000003; SHAMT_ZEXT=0 gives imm=0x00000403, fmt=1 in both.
4. Backpressure: out_ready=0, offer 3 instructions.
   - Two are accepted and in_ready drops to 0; the third is held.
   - Head stays stable for 5 cycles.
   - Raise out_ready: all three emerge in original order, with no loss or duplication.
5. Illegal opcode: 0x0000007F and 0x00000000 → fmt=7, illegal=1, imm=0, illegal_cnt=2.
   - With CNT_W=2, feed 5 illegal instructions → count saturates at 3.
6. Reset mid-stream: 2 entries buffered, assert rst asynchronously between edges.
   - out_valid=0 and illegal_cnt=0 immediately.
   - After release, the first new instruction appears with 1-cycle latency.
